// File: rtl/project_switch_pio_if.sv
// Avalon-MM slave bus bundle for the switch/button input PIO.
// Latency: n/a (signal grouping only).
// Backpressure: none; the slave never inserts wait states.
// Ports: address/chipselect/write_n/writedata from the master; readdata/irq from the slave.
interface project_switch_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/project_switch_pio.sv
// Input PIO: per-bit synchroniser, debounce, edge capture and maskable level irq.
// Latency: pin->DATA = SYNC_STAGES + DEBOUNCE_CYCLES edges to stable, +1 to readdata.
// Backpressure: none; reads return on the next edge, writes take effect on the strobe edge.
// Ports: clk, reset_n (async, active-low), bus (Avalon-MM slave: word regs DATA,
//        reserved, IRQ_MASK, EDGE_CAPTURE; plus irq), in_port (raw asynchronous pins).
module project_switch_pio #(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  project_switch_pio_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Synchroniser: stage 0 samples the pin, the last stage is the usable level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_d = sync_lvl;
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
      logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

      // The counter only runs while the synchronised level disagrees with the
      // accepted level; any return to agreement restarts the whole window.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int b = 0; b < WIDTH; b++) begin
          if (sync_lvl[b] == stable_q[b]) begin
            cnt_d[b] = '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            stable_d[b] = sync_lvl[b];
            cnt_d[b]    = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Edges are taken from the accepted level, so they appear on the same edge
  // that stable itself updates.
  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_set = stable_d & ~stable_q;
    end else if (EDGE_TYPE == 1) begin
      edge_set = ~stable_d & stable_q;
    end else begin
      edge_set = stable_d ^ stable_q;
    end
  end

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign wr_bits  = WIDTH'(bus.writedata);
  assign clr_bits = (wr_en && (bus.address == ADDR_EDGE)) ? wr_bits : '0;

  // OR-ing the new edges after the clear makes a same-edge set win.
  assign edge_d = (edge_q & ~clr_bits) | edge_set;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = 32'(stable_q);
      ADDR_RSVD: rd_mux = '0;
      ADDR_MASK: rd_mux = 32'(mask_q);
      ADDR_EDGE: rd_mux = 32'(edge_q);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q      <= '0;
      edge_q        <= '0;
      mask_q        <= '0;
      bus.readdata  <= '0;
      bus.irq       <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      edge_q       <= edge_d;
      if (wr_en && (bus.address == ADDR_MASK)) begin
        mask_q <= wr_bits;
      end
      bus.readdata <= rd_mux;
      bus.irq      <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_project_switch_pio.sv
// Bench for project_switch_pio: three parameterisations on a shared bus/reset,
// checked every cycle against a behavioural model plus literal expectations.
// Ports: none (top-level bench).
module tb_project_switch_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs;
  logic        write_n;
  logic [31:0] wdata;
  logic [2:0]  pin_a;
  logic [2:0]  pin_b;
  logic [7:0]  pin_c;

  int vectors;
  int bad;

  project_switch_pio_if bus_a ();
  project_switch_pio_if bus_b ();
  project_switch_pio_if bus_c ();

  assign bus_a.address = address;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = write_n;  assign bus_a.writedata  = wdata;
  assign bus_b.address = address;  assign bus_b.chipselect = cs;
  assign bus_b.write_n = write_n;  assign bus_b.writedata  = wdata;
  assign bus_c.address = address;  assign bus_c.chipselect = cs;
  assign bus_c.write_n = write_n;  assign bus_c.writedata  = wdata;

  project_switch_pio #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(pin_a));
  project_switch_pio #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(pin_b));
  project_switch_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .in_port(pin_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int p_w(input int d);
    return (d == 2) ? 8 : 3;
  endfunction
  function automatic int p_db(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 4 : 2);
  endfunction
  function automatic int p_et(input int d);
    return (d == 2) ? 2 : 0;
  endfunction

  logic [7:0]  m_pin    [3];
  logic [31:0] dut_rd   [3];
  logic        dut_irq  [3];
  logic [7:0]  m_sh0    [3];
  logic [7:0]  m_sh1    [3];
  logic [7:0]  m_stable [3];
  logic [7:0]  m_ecap   [3];
  logic [7:0]  m_mask   [3];
  int          m_run    [3][8];
  logic [31:0] m_rd     [3];
  logic        m_irq    [3];

  always_comb begin
    m_pin[0]   = {5'b0, pin_a};
    m_pin[1]   = {5'b0, pin_b};
    m_pin[2]   = pin_c;
    dut_rd[0]  = bus_a.readdata;
    dut_rd[1]  = bus_b.readdata;
    dut_rd[2]  = bus_c.readdata;
    dut_irq[0] = bus_a.irq;
    dut_irq[1] = bus_b.irq;
    dut_irq[2] = bus_c.irq;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        m_sh0[d] <= '0; m_sh1[d] <= '0; m_stable[d] <= '0;
        m_ecap[d] <= '0; m_mask[d] <= '0; m_rd[d] <= '0; m_irq[d] <= 1'b0;
        for (int b = 0; b < 8; b++) m_run[d][b] <= 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic [7:0] wm, nxt, set, clr, wbits;
        int run;
        wm  = 8'((1 << p_w(d)) - 1);
        nxt = m_stable[d];
        // Accept a new level once it has been seen on p_db consecutive edges.
        for (int b = 0; b < 8; b++) begin
          run = m_run[d][b];
          if (m_sh1[d][b] == m_stable[d][b]) begin
            run = 0;
          end else if (p_db(d) == 0) begin
            nxt[b] = m_sh1[d][b];
          end else begin
            run = run + 1;
            if (run == p_db(d)) begin
              nxt[b] = m_sh1[d][b];
              run = 0;
            end
          end
          m_run[d][b] <= run;
        end
        case (p_et(d))
          0:       set = nxt & ~m_stable[d];
          1:       set = ~nxt & m_stable[d];
          default: set = nxt ^ m_stable[d];
        endcase
        wbits = wdata[7:0] & wm;
        clr   = (cs && !write_n && address == 2'd3) ? wbits : 8'h00;
        case (address)
          2'd0:    m_rd[d] <= {24'h0, m_stable[d]};
          2'd2:    m_rd[d] <= {24'h0, m_mask[d]};
          2'd3:    m_rd[d] <= {24'h0, m_ecap[d]};
          default: m_rd[d] <= 32'h0;
        endcase
        m_irq[d]  <= |(m_ecap[d] & m_mask[d]);
        m_ecap[d] <= (m_ecap[d] & ~clr) | set;
        if (cs && !write_n && address == 2'd2) m_mask[d] <= wbits;
        m_stable[d] <= nxt;
        m_sh1[d]    <= m_sh0[d];
        m_sh0[d]    <= m_pin[d] & wm;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%h, expected 0x%h", nm, $time, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare every DUT against the model.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      lit($sformatf("model_rd_dut%0d", d), dut_rd[d], m_rd[d]);
      lit($sformatf("model_irq_dut%0d", d), {31'h0, dut_irq[d]}, {31'h0, m_irq[d]});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; cs = 1'b1; write_n = 1'b0; wdata = d;
    tick();
    cs = 1'b0; write_n = 1'b1; wdata = 32'h0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    logic found;
    vectors = 0; bad = 0;
    reset_n = 1'b0; address = 2'd0; cs = 1'b0; write_n = 1'b1; wdata = 32'h0;
    pin_a = 3'b111; pin_b = 3'b000; pin_c = 8'h00;

    // 1: reset with pins high, filter bypassed
    repeat (3) tick();
    lit("rst_rd_a", bus_a.readdata, 32'h0);
    lit("rst_irq_a", {31'h0, bus_a.irq}, 32'h0);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (bus_a.readdata == 32'h7) found = 1'b1;
    end
    lit("a_data_after_release", {31'h0, found}, 32'h1);
    address = 2'd3;
    tick();
    lit("a_ecap_after_release", bus_a.readdata, 32'h7);

    // 2: debounce timing and glitch rejection
    address = 2'd0;
    pin_b = 3'b001;
    repeat (6) tick();
    lit("b_data_edge6", bus_b.readdata, 32'h0);
    tick();
    lit("b_data_edge7", bus_b.readdata, 32'h1);
    pin_b = 3'b011;
    repeat (3) tick();
    pin_b = 3'b001;
    repeat (10) tick();
    lit("b_glitch_data", bus_b.readdata, 32'h1);
    address = 2'd3;
    tick();
    lit("b_glitch_ecap", bus_b.readdata, 32'h1);

    // 3: masked interrupt
    wr(2'd2, 32'h2);
    wr(2'd3, 32'hFF);
    address = 2'd3;
    pin_b = 3'b011;
    n = 0;
    while (!bus_b.irq && n < 12) begin
      tick();
      n++;
    end
    lit("b_irq_latency", n, 7);
    lit("b_ecap_bit1", bus_b.readdata, 32'h2);
    wr(2'd3, 32'h2);
    lit("b_irq_hold_on_clear_edge", {31'h0, bus_b.irq}, 32'h1);
    tick();
    lit("b_irq_cleared", {31'h0, bus_b.irq}, 32'h0);
    pin_b = 3'b010;
    repeat (10) tick();
    pin_b = 3'b011;
    repeat (10) tick();
    lit("b_ecap_unmasked_bit0", bus_b.readdata, 32'h1);
    lit("b_irq_unmasked_bit0", {31'h0, bus_b.irq}, 32'h0);

    // 4: clear and capture on the same edge
    pin_b = 3'b001;
    repeat (10) tick();
    wr(2'd3, 32'h7);
    pin_b = 3'b011;
    repeat (5) tick();
    wr(2'd3, 32'h2);
    tick();
    lit("b_collision_set_wins", bus_b.readdata, 32'h2);

    // 5: any-edge capture on a wide instance, masked-off upper bits, reserved word
    address = 2'd3;
    pin_c = 8'h80;
    repeat (8) tick();
    lit("c_rise_capture", bus_c.readdata, 32'h80);
    wr(2'd3, 32'hFF);
    tick();
    lit("c_cleared", bus_c.readdata, 32'h0);
    pin_c = 8'h00;
    repeat (8) tick();
    lit("c_fall_capture", bus_c.readdata, 32'h80);
    wr(2'd2, 32'hFFFF_FF00);
    tick();
    lit("c_mask_upper_ignored", bus_c.readdata, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    tick();
    lit("c_reserved_reads_zero", bus_c.readdata, 32'h0);

    // 6: reset in the middle of a debounce window
    address = 2'd0;
    pin_b = 3'b000;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    pin_b = 3'b100;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    lit("b_rd_in_reset", bus_b.readdata, 32'h0);
    reset_n = 1'b1;
    repeat (6) tick();
    lit("b_rerun_edge6", bus_b.readdata, 32'h0);
    tick();
    lit("b_rerun_edge7", bus_b.readdata, 32'h4);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, bad);
    $finish;
  end

endmodule
